// File: rtl/mix_pkg.sv
// Shared defaults and state type for the voice mix sequencer.
// Contents:
//   NUM_VOICES_DEF / SAMPLE_W_DEF / ACC_W_DEF - default build parameters
//   mix_state_t                               - sequencer state encoding
package mix_pkg;

  localparam int unsigned NUM_VOICES_DEF = 12;
  localparam int unsigned SAMPLE_W_DEF   = 8;
  localparam int unsigned ACC_W_DEF      = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } mix_state_t;

endpackage

// File: rtl/mix_sequencer.sv
// Time-multiplexed voice mixer. Each sample_tick starts a scan that reads one
// voice per cycle through a single adder, then presents the saturated sum on
// a valid/ready output.
// Ports:
//   clk, nrst        - clock, asynchronous active-low reset
//   sample_tick      - one-cycle strobe starting a mix period
//   voice_enable     - per-voice enable, latched when a mix starts
//   voice_sel        - index of the voice being read (0 outside a scan)
//   voice_sample     - sample of voice voice_sel, same cycle
//   out_sample       - mixed, saturated sample
//   out_valid        - out_sample valid, held until out_ready
//   out_ready        - downstream accept
//   busy             - scan or output hold in progress
//   overrun          - one-cycle pulse when a sample_tick is dropped
//   clip             - (MIX_CLIP_DETECT_EN only) sticky saturation flag
// Build option: define MIX_CLIP_DETECT_EN to add the clip output.
module mix_sequencer
  import mix_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  localparam int unsigned SEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES-1:0] voice_enable,
  output logic [SEL_W-1:0]      voice_sel,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  output logic [SAMPLE_W-1:0]   out_sample,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun
`ifdef MIX_CLIP_DETECT_EN
  ,
  output logic                  clip
`endif
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_VOICES - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'({SAMPLE_W{1'b1}});

  mix_state_t            state_q, state_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SAMPLE_W-1:0]   out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
`ifdef MIX_CLIP_DETECT_EN
  logic                  clip_q, clip_d;
  logic                  sat_q, sat_d;
`endif

  logic [ACC_W-1:0]      addend;
  logic [ACC_W-1:0]      acc_sum;
  logic                  sat;
  logic                  handshake;
  logic                  tick_accept;

  // Single shared adder: current voice contributes only if enabled at mix start
  always_comb begin
    addend  = en_q[sel_q] ? ACC_W'(voice_sample) : '0;
    acc_sum = acc_q + addend;
    sat     = (acc_sum > SAT_MAX);
  end

  // A tick is taken when idle, or when the held result is accepted that cycle
  always_comb begin
    handshake   = (state_q == OUT) && out_ready;
    tick_accept = sample_tick && ((state_q == IDLE) || handshake);
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef MIX_CLIP_DETECT_EN
    clip_d  = clip_q;
    sat_d   = sat_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SCAN: begin
        ovr_d = sample_tick;
        acc_d = acc_sum;
        if (sel_q == LAST_SEL) begin
          out_d   = sat ? '1 : acc_sum[SAMPLE_W-1:0];
          valid_d = 1'b1;
          sel_d   = '0;
          state_d = OUT;
`ifdef MIX_CLIP_DETECT_EN
          sat_d   = sat;
          if (sat) begin
            clip_d = 1'b1;
          end
`endif
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
      OUT: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = IDLE;
`ifdef MIX_CLIP_DETECT_EN
          if (!sat_q) begin
            clip_d = 1'b0;
          end
`endif
        end else begin
          ovr_d = sample_tick;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = '0;
      end
    endcase

    // Start of a new mix (from IDLE or back-to-back after an accept)
    if (tick_accept) begin
      en_d    = voice_enable;
      acc_d   = '0;
      sel_d   = '0;
      state_d = SCAN;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      en_q    <= '0;
      acc_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef MIX_CLIP_DETECT_EN
      clip_q  <= 1'b0;
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef MIX_CLIP_DETECT_EN
      clip_q  <= clip_d;
      sat_q   <= sat_d;
`endif
    end
  end

  assign voice_sel  = sel_q;
  assign out_sample = out_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
`ifdef MIX_CLIP_DETECT_EN
  assign clip       = clip_q;
`endif

endmodule

// File: tb/tb_mix_sequencer.sv
// Self-checking bench for mix_sequencer: a transaction-level model predicts
// outputs every cycle, directed scenarios add hand-computed literal checks.
module tb_mix_sequencer;

  localparam int NV   = 12;
  localparam int SW   = 8;
  localparam int SELW = $clog2(NV);
  localparam int SMAX = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            sample_tick = 1'b0;
  logic            out_ready = 1'b0;
  logic [NV-1:0]   voice_enable = '0;
  logic [SELW-1:0] voice_sel;
  logic [SW-1:0]   voice_sample;
  logic [SW-1:0]   out_sample;
  logic            out_valid;
  logic            busy;
  logic            overrun;
`ifdef MIX_CLIP_DETECT_EN
  logic            clip;
`endif

  logic [SW-1:0]   voices [NV];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_hs     = 0;

  // Model: cycles of scan remaining, held result, overrun pulse
  int   scan_left = 0;
  logic m_valid   = 1'b0;
  int   m_out     = 0;
  int   m_pend    = 0;
  logic m_ovr     = 1'b0;

  mix_sequencer dut (
    .clk          (clk),
    .nrst         (nrst),
    .sample_tick  (sample_tick),
    .voice_enable (voice_enable),
    .voice_sel    (voice_sel),
    .voice_sample (voice_sample),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun)
`ifdef MIX_CLIP_DETECT_EN
    ,
    .clip         (clip)
`endif
  );

  always #5 clk = ~clk;

  assign voice_sample = (int'(voice_sel) < NV) ? voices[voice_sel] : '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Saturated sum of the enabled voices
  function automatic int exp_mix(input logic [NV-1:0] en);
    int s;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) s += int'(voices[i]);
    end
    return (s > SMAX) ? SMAX : s;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (nrst && out_valid && out_ready) n_hs++;
  end

  // Model update on the edge, compare just after it
  always @(posedge clk) begin
    logic t;
    logic r;
    t = sample_tick;
    r = out_ready;
    if (!nrst) begin
      scan_left = 0;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
    end else begin
      m_ovr = 1'b0;
      if (m_valid) begin
        if (r) begin
          m_valid = 1'b0;
          if (t) begin
            scan_left = NV;
            m_pend    = exp_mix(voice_enable);
          end
        end else if (t) begin
          m_ovr = 1'b1;
        end
      end else if (scan_left > 0) begin
        if (t) m_ovr = 1'b1;
        scan_left--;
        if (scan_left == 0) begin
          m_valid = 1'b1;
          m_out   = m_pend;
        end
      end else if (t) begin
        scan_left = NV;
        m_pend    = exp_mix(voice_enable);
      end
    end
    #1;
    chk("model_valid", int'(out_valid), int'(m_valid));
    chk("model_busy", int'(busy), int'(m_valid || scan_left > 0));
    chk("model_overrun", int'(overrun), int'(m_ovr));
    chk("model_sel", int'(voice_sel), (scan_left > 0) ? NV - scan_left : 0);
    if (m_valid) chk("model_out", int'(out_sample), m_out);
    if (!nrst) chk("model_rst_out", int'(out_sample), 0);
  end

  task automatic do_tick(output int t0);
    @(negedge clk);
    sample_tick = 1'b1;
    t0 = cyc;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input int t0, output int lat);
    int k;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (out_valid) begin
      lat = cyc - t0;
    end else begin
      lat = -1;
      chk("valid_timeout", 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    int hs0;
    int vcount;

    for (int i = 0; i < NV; i++) voices[i] = 8'd7;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(voice_sel), 0);
    chk("rst_out", int'(out_sample), 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Two voices: 100 + 50
    voices[0] = 8'd100;
    voices[1] = 8'd50;
    voice_enable = 12'h003;
    out_ready = 1'b1;
    do_tick(t0);
    wait_valid(t0, lat);
    chk("s1_latency", lat, 13);
    chk("s1_out", int'(out_sample), 150);
    @(negedge clk);
    chk("s1_one_cycle", int'(out_valid), 0);

    // All voices 200: saturates
    for (int i = 0; i < NV; i++) voices[i] = 8'd200;
    voice_enable = 12'hFFF;
    do_tick(t0);
    wait_valid(t0, lat);
    chk("s2_latency", lat, 13);
    chk("s2_out", int'(out_sample), 255);
    @(negedge clk);

    // No voices enabled
    voice_enable = 12'h000;
    do_tick(t0);
    wait_valid(t0, lat);
    chk("s2z_latency", lat, 13);
    chk("s2z_out", int'(out_sample), 0);
    @(negedge clk);

    // Back-pressure with a dropped tick during the hold
    for (int i = 0; i < NV; i++) voices[i] = 8'd30;
    voice_enable = 12'h00F;
    out_ready = 1'b0;
    do_tick(t0);
    wait_valid(t0, lat);
    chk("s3_latency", lat, 13);
    hs0 = n_hs;
    for (int k = 1; k <= 5; k++) begin
      chk("s3_hold_valid", int'(out_valid), 1);
      chk("s3_hold_out", int'(out_sample), 120);
      chk("s3_overrun", int'(overrun), (k == 3) ? 1 : 0);
      sample_tick = (k == 2);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("s3_released", int'(out_valid), 0);
    repeat (20) @(negedge clk);
    chk("s3_single_output", n_hs - hs0, 1);

    // Tick coincident with accept: next mix starts with no overrun
    voice_enable = 12'h003;
    out_ready = 1'b0;
    do_tick(t0);
    wait_valid(t0, lat);
    chk("s4_first_out", int'(out_sample), 60);
    sample_tick = 1'b1;
    out_ready = 1'b1;
    voice_enable = 12'h007;
    t0 = cyc;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("s4_no_overrun", int'(overrun), 0);
    chk("s4_busy", int'(busy), 1);
    wait_valid(t0, lat);
    chk("s4_latency", lat, 13);
    chk("s4_second_out", int'(out_sample), 90);
    @(negedge clk);

    // Enable change mid-scan must not affect the current mix
    for (int i = 0; i < NV; i++) voices[i] = 8'd20;
    voices[0] = 8'd10;
    voice_enable = 12'h001;
    do_tick(t0);
    repeat (2) @(negedge clk);
    voice_enable = 12'hFFF;
    wait_valid(t0, lat);
    chk("s5_latency", lat, 13);
    chk("s5_out", int'(out_sample), 10);
    @(negedge clk);

    // Reset in the middle of a scan
    do_tick(t0);
    repeat (5) @(negedge clk);
    chk("s6_pre_sel", int'(voice_sel), 5);
    chk("s6_pre_busy", int'(busy), 1);
    nrst = 1'b0;
    #1;
    chk("s6_rst_sel", int'(voice_sel), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_valid", int'(out_valid), 0);
    chk("s6_rst_out", int'(out_sample), 0);
    chk("s6_rst_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("s6_no_valid_after_rst", vcount, 0);

    // Fresh mix after reset: voices 0 and 2 -> 10 + 20
    voice_enable = 12'h005;
    do_tick(t0);
    wait_valid(t0, lat);
    chk("s6_latency", lat, 13);
    chk("s6_out", int'(out_sample), 30);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_sequencer.md
MIX_SEQUENCER -- requirements
Module: mix_sequencer

Interface
REQ-001 Parameter NUM_VOICES, default 12: number of voice channels scanned per sample period.
REQ-002 Parameter SAMPLE_W, default 8: unsigned voice and output sample width.
REQ-003 Parameter ACC_W, default 12: accumulator width, SHALL be >= SAMPLE_W + clog2(NUM_VOICES).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 nrst  in  1  reset, asynchronous, active-low.
REQ-006 sample_tick  in  1  single-cycle strobe starting one mix period.
REQ-007 voice_enable  in  NUM_VOICES  per-voice enable, bit i = voice i.
REQ-008 voice_sel  out  clog2(NUM_VOICES)  index of voice currently read.
REQ-009 voice_sample  in  SAMPLE_W  sample of voice voice_sel, valid combinationally in the same cycle.
REQ-010 out_sample  out  SAMPLE_W  mixed, saturated sample.
REQ-011 out_valid  out  1  out_sample valid; held until accepted.
REQ-012 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-013 busy  out  1  high in SCAN or OUT.
REQ-014 overrun  out  1  one-cycle pulse when a sample_tick is dropped.

Function
REQ-015 FSM states IDLE, SCAN, OUT; SCAN reads one voice per cycle (time-multiplexed, single adder).
REQ-016 IDLE + sample_tick: latch voice_enable into en_q, clear acc, voice_sel <= 0, go SCAN.
REQ-017 SCAN each cycle: if en_q[voice_sel], acc <= acc + voice_sample (zero-extended); voice_sel increments.
REQ-018 SCAN with voice_sel == NUM_VOICES-1: after final add, out_sample <= (acc_next > 2^SAMPLE_W-1) ? all-ones : acc_next[SAMPLE_W-1:0]; out_valid <= 1; go OUT.
REQ-019 Latency: tick at cycle T -> out_valid high at T+NUM_VOICES+1 (T+13 default).
REQ-020 OUT: out_sample and out_valid held stable until out_valid && out_ready; then out_valid <= 0, go IDLE.
REQ-021 OUT handshake coincident with sample_tick: tick accepted, go directly to SCAN per REQ-016, no overrun.
REQ-022 sample_tick in SCAN, or in OUT without handshake: tick ignored, overrun pulses next cycle, state unaffected.
REQ-023 voice_enable changes during SCAN SHALL not affect the current mix (en_q used).
REQ-024 All enables zero: out_sample = 0 after full scan, same latency.
REQ-025 acc never wraps: ACC_W per REQ-003 holds NUM_VOICES x (2^SAMPLE_W-1).
REQ-026 voice_sel SHALL be 0 outside SCAN.

Reset
REQ-027 nrst low asynchronously forces IDLE, acc=0, en_q=0, voice_sel=0, out_sample=0, out_valid=0, busy=0, overrun=0 (and clip=0 if built).
REQ-028 Reset mid-SCAN or mid-OUT abandons the mix; no out_valid after release until a new tick.

Configuration
REQ-029 Macro MIX_CLIP_DETECT_EN defined: extra output clip (1 bit), set when a completed mix saturated (acc_next > 2^SAMPLE_W-1), sticky until the next accepted handshake of an unsaturated mix; updated with out_valid.
REQ-030 MIX_CLIP_DETECT_EN undefined: no clip port, no clip logic; all other behaviour identical.

Structure
REQ-031 Package mix_pkg SHALL hold NUM_VOICES, SAMPLE_W, ACC_W defaults and typedef mix_state_t {IDLE, SCAN, OUT}.
REQ-032 No sub-module; saturation is inline combinational logic in mix_sequencer.

Verification
REQ-033 Enables 0x003, voices 0,1 = 100, 50, tick, out_ready=1 -> out_sample=150, out_valid at T+13 for 1 cycle.
REQ-034 Enables 0xFFF, all voices = 200 -> out_sample=255 (clip=1 if MIX_CLIP_DETECT_EN).
REQ-035 out_ready=0 for 5 cycles after out_valid, tick at cycle 2 of hold -> out_sample stable, overrun pulse, single output on accept.
REQ-036 Tick in same cycle as accept -> next mix starts, no overrun, next out_valid 13 cycles later.
REQ-037 Flip voice_enable 0x001 -> 0xFFF at SCAN cycle 3, voice 0=10, others 20 -> out_sample=10.
REQ-038 nrst low at SCAN cycle 6 -> all outputs 0 immediately; no out_valid until next tick.
